// File: rtl/imm_encoder.sv
// Packs a signed immediate into the I-type or B-type fields of an instruction word,
// range-checks it, and queues the result with a sequential memory address.
module imm_encoder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_imm_src,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [DATA_WIDTH-1:0] in_base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_addr,
    output logic                  out_err,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      err_mem;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  live;
    logic                  full, push, pop;
    logic [DATA_WIDTH-1:0] enc_word;
    logic                  enc_err, i_ok, b_ok;

    assign full      = (count == (PW+1)'(DEPTH));
    assign in_ready  = live && !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // In range when all bits above the field's sign bit match it.
    assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];

    always_comb begin
        enc_word = in_base;
        enc_err  = 1'b0;
        if (in_imm_src) begin
            enc_word[31]    = in_imm[12];
            enc_word[30:25] = in_imm[10:5];
            enc_word[11:8]  = in_imm[4:1];
            enc_word[7]     = in_imm[11];
            enc_err         = !b_ok;
        end else begin
            enc_word[31:20] = in_imm[11:0];
            enc_err         = !i_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]     <= enc_word;
            err_mem[wr_ptr] <= enc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= BASE_ADDR;
            err_cnt  <= '0;
        end else begin
            live <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_addr <= out_addr + DATA_WIDTH'(4);
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push && enc_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_instr = out_valid ? mem[rd_ptr] : '0;
    assign out_err   = out_valid ? err_mem[rd_ptr] : 1'b0;
endmodule
